// File: rtl/scan_sequencer_3b_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : scan_sequencer_3b_pkg                                           |
// | Brief  : Shared constants for the 3-bit scan sequencer: FSM encoding and |
// |          channel count.                                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package scan_sequencer_3b_pkg;

  // FSM encoding
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Number of scanned channels and the index of the highest one
  localparam int         NCH     = 8;
  localparam logic [2:0] CH_LAST = 3'(NCH - 1);

endpackage
`default_nettype wire

// File: rtl/scan_sequencer_3b_next_enabled_3b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : next_enabled_3b                                                 |
// | Brief  : Combinational circular priority search. Finds the first set bit |
// |          of mask starting at cur+1 and wrapping; cur itself is tried     |
// |          last so a single-bit mask re-selects the same channel.          |
// | Ports  : mask[7:0] in  - channel enable mask                             |
// |          cur[2:0]  in  - current channel                                 |
// |          nxt[2:0]  out - next enabled channel                            |
// |          wrap      out - nxt <= cur (search went round the end)          |
// |          none      out - mask is all zero (nxt is meaningless)           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module next_enabled_3b
  import scan_sequencer_3b_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [2:0]     cur,
  output logic [2:0]     nxt,
  output logic           wrap,
  output logic           none
);

  logic [2:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites
  // the others; offset NCH lands back on cur (3-bit truncation).
  always_comb begin
    nxt = cur;
    idx = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (mask[idx]) begin
        nxt = idx;
      end
    end
    wrap = (nxt <= cur);
    none = (mask == '0);
  end

endmodule
`default_nettype wire

// File: rtl/scan_sequencer_3b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : scan_sequencer_3b                                               |
// | Brief  : Steps a 3-bit channel index through the channels enabled in an  |
// |          8-bit mask, holding each for a programmable dwell. Continuous   |
// |          or single-sweep. All outputs are registered.                    |
// | Ports  : clk, rst_n (async, active-low)                                  |
// |          start, stop, oneshot, enable_mask[7:0], dwell[DWELL_W-1:0] in   |
// |          sel[2:0], sel_en, busy                                     out  |
// |          step_pulse, wrap_pulse, done_pulse, err_pulse              out  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module scan_sequencer_3b
  import scan_sequencer_3b_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic [7:0]         enable_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               step_pulse,
  output logic               wrap_pulse,
  output logic               done_pulse,
  output logic               err_pulse
);

  logic [0:0]         state;
  logic [DWELL_W-1:0] count;
  logic [DWELL_W-1:0] dwell_q;
  logic               oneshot_q;

  logic [2:0]         search_cur;
  logic [2:0]         nxt;
  logic               nxt_wrap;
  logic               mask_none;
  logic [DWELL_W-1:0] last_cnt;
  logic               at_last;

  // In IDLE, searching from the last channel yields the lowest set bit,
  // so one search instance serves both start and advance.
  assign search_cur = (state == ST_IDLE) ? CH_LAST : sel;

  // Dwell of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign last_cnt = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  assign at_last  = (count == last_cnt);

  next_enabled_3b u_next (
    .mask (enable_mask),
    .cur  (search_cur),
    .nxt  (nxt),
    .wrap (nxt_wrap),
    .none (mask_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      dwell_q    <= '0;
      oneshot_q  <= 1'b0;
      sel        <= '0;
      sel_en     <= 1'b0;
      busy       <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;

      if (stop) begin
        state  <= ST_IDLE;
        sel    <= '0;
        sel_en <= 1'b0;
        busy   <= 1'b0;
        count  <= '0;
      end else if (state == ST_IDLE) begin
        if (start) begin
          if (mask_none) begin
            err_pulse <= 1'b1;
          end else begin
            state      <= ST_ACTIVE;
            sel        <= nxt;
            sel_en     <= 1'b1;
            busy       <= 1'b1;
            step_pulse <= 1'b1;
            count      <= '0;
            dwell_q    <= dwell;
            oneshot_q  <= oneshot;
          end
        end
      end else if (at_last) begin
        if (mask_none || (nxt_wrap && oneshot_q)) begin
          // End of scan: either an empty mask or a completed single sweep
          state      <= ST_IDLE;
          sel        <= '0;
          sel_en     <= 1'b0;
          busy       <= 1'b0;
          count      <= '0;
          err_pulse  <= mask_none;
          done_pulse <= ~mask_none;
        end else begin
          sel        <= nxt;
          count      <= '0;
          step_pulse <= 1'b1;
          wrap_pulse <= nxt_wrap;
          dwell_q    <= dwell;
        end
      end else begin
        count <= count + DWELL_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer_3b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_scan_sequencer_3b                                            |
// | Brief  : Self-checking bench for scan_sequencer_3b: directed scenarios   |
// |          with literal expectations plus a randomized run compared every  |
// |          cycle against a behavioural slot/countdown model.               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_scan_sequencer_3b;

  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               oneshot = 1'b0;
  logic [7:0]         enable_mask = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [2:0]         sel;
  logic               sel_en, busy, step_pulse, wrap_pulse, done_pulse, err_pulse;

  int nvec = 0;
  int nfail = 0;

  scan_sequencer_3b #(.DWELL_W(DWELL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .oneshot     (oneshot),
    .enable_mask (enable_mask),
    .dwell       (dwell),
    .sel         (sel),
    .sel_en      (sel_en),
    .busy        (busy),
    .step_pulse  (step_pulse),
    .wrap_pulse  (wrap_pulse),
    .done_pulse  (done_pulse),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A scan is a current channel plus the number of cycles left in its slot.
  bit m_active = 0;
  int m_chan = 0;
  int m_left = 0;
  bit m_one = 0;
  bit e_step = 0, e_wrap = 0, e_done = 0, e_err = 0;

  function automatic int first_from(input logic [7:0] m, input int s);
    for (int k = 0; k < 8; k++) begin
      if (m[(s + k) % 8]) return (s + k) % 8;
    end
    return -1;
  endfunction

  function automatic int eff(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_chan = 0; m_left = 0; m_one = 0;
      e_step = 0; e_wrap = 0; e_done = 0; e_err = 0;
    end else begin
      int nx;
      e_step = 0; e_wrap = 0; e_done = 0; e_err = 0;
      if (stop) begin
        m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          if (enable_mask == 0) e_err = 1;
          else begin
            m_active = 1;
            m_chan   = first_from(enable_mask, 0);
            m_left   = eff(int'(dwell));
            m_one    = oneshot;
            e_step   = 1;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (enable_mask == 0) begin
            m_active = 0;
            e_err = 1;
          end else begin
            nx = first_from(enable_mask, (m_chan + 1) % 8);
            if (nx <= m_chan && m_one) begin
              m_active = 0;
              e_done = 1;
            end else begin
              e_wrap = (nx <= m_chan);
              m_chan = nx;
              m_left = eff(int'(dwell));
              e_step = 1;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_sel",    int'(sel),        m_active ? m_chan : 0);
    chk("m_sel_en", int'(sel_en),     int'(m_active));
    chk("m_busy",   int'(busy),       int'(m_active));
    chk("m_step",   int'(step_pulse), int'(e_step));
    chk("m_wrap",   int'(wrap_pulse), int'(e_wrap));
    chk("m_done",   int'(done_pulse), int'(e_done));
    chk("m_err",    int'(err_pulse),  int'(e_err));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] m, input int d, input bit one);
    enable_mask = m;
    dwell       = DWELL_W'(d);
    oneshot     = one;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({step_pulse, wrap_pulse, done_pulse, err_pulse, sel_en}), 0);
    rst_n = 1'b1;
    tick();

    // Full mask, dwell 2, continuous: 0,0,1,1,...,7,7,0
    go(8'hFF, 2, 0);
    chk("ff_c0_sel", int'(sel), 0);
    chk("ff_c0_step", int'(step_pulse), 1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("ff_sel", int'(sel), (c / 2) % 8);
      chk("ff_busy", int'(busy), 1);
      chk("ff_wrap", int'(wrap_pulse), (c == 16) ? 1 : 0);
    end
    halt();
    chk("ff_stopped", int'(busy), 0);

    // Sparse mask 1010_0100, dwell 1, oneshot: 2,5,7 then done
    go(8'hA4, 1, 1);
    chk("os_sel0", int'(sel), 2);
    tick(); chk("os_sel1", int'(sel), 5);
    tick(); chk("os_sel2", int'(sel), 7);
    chk("os_step2", int'(step_pulse), 1);
    tick();
    chk("os_done", int'(done_pulse), 1);
    chk("os_idle", int'({busy, sel_en, sel}), 0);
    tick();
    chk("os_done_clr", int'(done_pulse), 0);

    // Start with an empty mask
    go(8'h00, 2, 0);
    chk("err_pulse", int'(err_pulse), 1);
    chk("err_busy", int'(busy), 0);
    tick();
    chk("err_clr", int'(err_pulse), 0);

    // Single channel 4, dwell 3: re-selected with step+wrap every 3 cycles
    go(8'h10, 3, 0);
    chk("one_sel", int'(sel), 4);
    chk("one_wrap0", int'(wrap_pulse), 0);
    tick(); chk("one_step1", int'(step_pulse), 0);
    tick();
    tick(); chk("one_wrap3", int'({step_pulse, wrap_pulse}), 3);
    tick(); tick(); tick();
    chk("one_wrap6", int'({step_pulse, wrap_pulse}), 3);
    chk("one_sel6", int'(sel), 4);
    halt();

    // Mask change mid-dwell on channel 1: 06 -> 42, next is 6
    go(8'h06, 3, 0);
    chk("mc_sel0", int'(sel), 1);
    tick();
    enable_mask = 8'h42;
    tick(); chk("mc_hold", int'(sel), 1);
    tick(); chk("mc_next", int'(sel), 6);
    halt();

    // Stop coinciding with an advance
    go(8'hFF, 2, 0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sa_busy", int'(busy), 0);
    chk("sa_sel", int'(sel), 0);
    chk("sa_step", int'(step_pulse), 0);
    tick();

    // Dwell 0 behaves as dwell 1
    go(8'h03, 0, 0);
    chk("d0_sel0", int'(sel), 0);
    tick(); chk("d0_sel1", int'(sel), 1);
    chk("d0_step1", int'(step_pulse), 1);
    tick(); chk("d0_wrap", int'({sel, step_pulse, wrap_pulse}), 3);
    halt();

    // Asynchronous reset mid-scan clears outputs without a clock edge
    go(8'hFF, 5, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_outs", int'({sel, sel_en, busy, step_pulse, wrap_pulse, done_pulse, err_pulse}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom % 8) == 0;
      stop    = ($urandom % 40) == 0;
      oneshot = $urandom % 2;
      dwell   = DWELL_W'($urandom % 5);
      if (($urandom % 12) == 0)
        enable_mask = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
      if (($urandom % 700) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    start = 1'b0;
    stop  = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
